// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: pipeline-latch control, MEM-stage FSM states and word type.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINK_W = 30;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        PIPE_ENABLE = 2'd0,
        PIPE_STALL  = 2'd1,
        PIPE_NOP    = 2'd2
    } pipe_state_t;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } memstate_t;

    // Word address used for LL/SC linking (byte offset dropped).
    function automatic logic [LINK_W-1:0] word_addr(input word_t a);
        return a[WORD_W-1:WORD_W-LINK_W];
    endfunction

endpackage

// File: rtl/link_register.sv
// LL/SC link register: remembers the last LL word address; cleared by stores, SCs and snoops.
module link_register #(
    parameter int unsigned LINK_W = 30
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set,
    input  logic              clear,
    input  logic [LINK_W-1:0] set_addr,
    input  logic [LINK_W-1:0] check_addr,
    input  logic              snoop_inv,
    input  logic [LINK_W-1:0] snoop_addr,
    output logic              valid,
    output logic              match_c
);

    logic [LINK_W-1:0] link_addr;
    logic              valid_n;

    assign match_c = (link_addr == check_addr);

    // A snoop to the word being linked this cycle overrides the new link.
    always_comb begin
        valid_n = valid;
        if (set) begin
            valid_n = !(snoop_inv && (snoop_addr == set_addr));
        end else if (clear || (snoop_inv && (snoop_addr == link_addr))) begin
            valid_n = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid     <= 1'b0;
            link_addr <= '0;
        end else begin
            valid <= valid_n;
            if (set) begin
                link_addr <= set_addr;
            end
        end
    end

endmodule

// File: rtl/pipeline_memory_stage.sv
// MEM-stage controller: data-cache handshake, miss stall, load capture and LL/SC link tracking.
module pipeline_memory_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned WORD_W = cpu_types_pkg::WORD_W,
    parameter int unsigned LINK_W = cpu_types_pkg::LINK_W
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_mem,
    input  logic              dREN_mem,
    input  logic              dWEN_mem,
    input  logic              ll_mem,
    input  logic              sc_mem,
    input  logic [WORD_W-1:0] addr_mem,
    input  logic [WORD_W-1:0] store_data_mem,
    input  logic              hold_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [WORD_W-1:0] snoop_addr,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload_mem,
    output logic              mem_stall,
    output pipe_state_t       mw_state
);

    memstate_t         state, state_n;
    logic [WORD_W-1:0] data_q, data_d;
    logic              req_en;
    logic              complete;
    logic              link_valid;
    logic              link_match_c;
    logic              unused_low_bits;

    logic              is_mem, is_sc, sc_fail, memop;
    logic [WORD_W-1:0] hit_value;

    assign unused_low_bits = ^{addr_mem[1:0], snoop_addr[1:0]};

    assign is_mem    = valid_mem && (dREN_mem || dWEN_mem);
    assign is_sc     = valid_mem && dWEN_mem && sc_mem;
    // SC success is decided when it enters the stage; once issued it is not re-judged.
    assign sc_fail   = (state == MEM_IDLE) && is_sc && !(link_valid && link_match_c);
    assign memop     = is_mem && !sc_fail;
    assign hit_value = is_sc ? WORD_W'(1) : dmemload;

    assign dmemaddr  = {addr_mem[WORD_W-1:2], 2'b00};
    assign dmemstore = store_data_mem;
    assign dmemREN   = req_en && dREN_mem;
    assign dmemWEN   = req_en && dWEN_mem;

    // Next state and outputs; everything is forced quiet while reset is asserted.
    always_comb begin
        state_n      = state;
        data_d       = data_q;
        req_en       = 1'b0;
        complete     = 1'b0;
        mem_stall    = 1'b0;
        mw_state     = PIPE_ENABLE;
        dmemload_mem = '0;
        if (nRST) begin
            unique case (state)
                MEM_IDLE: begin
                    if (sc_fail) begin
                        complete = 1'b1;
                        mw_state = hold_in ? PIPE_STALL : PIPE_ENABLE;
                    end else if (memop) begin
                        req_en = 1'b1;
                        if (dhit) begin
                            complete     = 1'b1;
                            dmemload_mem = hit_value;
                            data_d       = hit_value;
                            if (hold_in) begin
                                state_n  = MEM_DONE;
                                mw_state = PIPE_STALL;
                            end
                        end else begin
                            state_n   = MEM_WAIT;
                            mem_stall = 1'b1;
                            mw_state  = PIPE_STALL;
                        end
                    end else begin
                        mw_state = hold_in ? PIPE_STALL : PIPE_ENABLE;
                    end
                end
                MEM_WAIT: begin
                    req_en = 1'b1;
                    if (dhit) begin
                        complete     = 1'b1;
                        dmemload_mem = hit_value;
                        data_d       = hit_value;
                        if (hold_in) begin
                            state_n  = MEM_DONE;
                            mw_state = PIPE_STALL;
                        end else begin
                            state_n = MEM_IDLE;
                        end
                    end else begin
                        mem_stall = 1'b1;
                        mw_state  = PIPE_STALL;
                    end
                end
                MEM_DONE: begin
                    dmemload_mem = data_q;
                    if (hold_in) begin
                        mem_stall = 1'b1;
                        mw_state  = PIPE_STALL;
                    end else begin
                        state_n = MEM_IDLE;
                    end
                end
                default: state_n = MEM_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= MEM_IDLE;
            data_q <= '0;
        end else begin
            state  <= state_n;
            data_q <= data_d;
        end
    end

    link_register #(
        .LINK_W(LINK_W)
    ) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (complete && dREN_mem && ll_mem),
        .clear      (complete && dWEN_mem && (sc_mem || link_match_c)),
        .set_addr   (addr_mem[WORD_W-1:2]),
        .check_addr (addr_mem[WORD_W-1:2]),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr[WORD_W-1:2]),
        .valid      (link_valid),
        .match_c    (link_match_c)
    );

endmodule

// File: tb/tb_pipeline_memory_stage.sv
// Self-checking bench for pipeline_memory_stage: directed scenarios plus random instruction streams vs a transaction model.
module tb_pipeline_memory_stage;
    import cpu_types_pkg::*;

    localparam int K_NOP = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_LL  = 3;
    localparam int K_SC  = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        valid_mem, dREN_mem, dWEN_mem, ll_mem, sc_mem;
    logic [31:0] addr_mem, store_data_mem;
    logic        hold_in, dhit, snoop_inv;
    logic [31:0] dmemload, snoop_addr;
    logic        dmemREN, dmemWEN, mem_stall;
    logic [31:0] dmemaddr, dmemstore, dmemload_mem;
    pipe_state_t mw_state;

    int checks   = 0;
    int failures = 0;

    // Reference link state: one remembered word address plus a valid flag.
    bit          m_valid = 1'b0;
    logic [29:0] m_word  = '0;

    always #5 CLK = ~CLK;

    pipeline_memory_stage dut (
        .CLK(CLK), .nRST(nRST), .valid_mem(valid_mem), .dREN_mem(dREN_mem),
        .dWEN_mem(dWEN_mem), .ll_mem(ll_mem), .sc_mem(sc_mem), .addr_mem(addr_mem),
        .store_data_mem(store_data_mem), .hold_in(hold_in), .dhit(dhit),
        .dmemload(dmemload), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dmemload_mem(dmemload_mem), .mem_stall(mem_stall), .mw_state(mw_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    task automatic drive_idle();
        valid_mem = 0; dREN_mem = 0; dWEN_mem = 0; ll_mem = 0; sc_mem = 0;
        addr_mem = 0; store_data_mem = 0; hold_in = 0; dhit = 0; dmemload = 0;
        snoop_inv = 0; snoop_addr = 0;
    endtask

    // One instruction: lat = wait cycles before dhit, hold = cycles hold_in stays high from the hit.
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rd, input int lat_in, input int hold_in_cycles,
                          input int snoop_k, input logic [31:0] saddr);
        bit          pass, rdop, wrop, req;
        int          n, lat, hold;
        logic [31:0] result;
        bit          e_stall;
        pipe_state_t e_mw;
        logic [31:0] e_load;
        rdop = (kind == K_LW) || (kind == K_LL);
        wrop = (kind == K_SW) || (kind == K_SC);
        pass = (kind != K_SC) || (m_valid && (m_word == addr[31:2]));
        lat  = lat_in;
        hold = hold_in_cycles;
        if (kind == K_NOP || !pass) begin
            lat = 0;
            if (!pass) hold = 0;
            n = 1;
        end else begin
            n = lat + hold + 1;
        end
        result = (kind == K_SC) ? 32'd1 : rd;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            valid_mem = (kind != K_NOP);
            dREN_mem = rdop; dWEN_mem = wrop;
            ll_mem = (kind == K_LL); sc_mem = (kind == K_SC);
            addr_mem = addr; store_data_mem = sdata;
            dhit = (kind != K_NOP) && pass && (k == lat);
            dmemload = (k == lat) ? rd : $urandom;
            if (kind == K_NOP)  hold_in = (hold != 0);
            else if (k < lat)   hold_in = 1'($urandom_range(1, 0));
            else                hold_in = (k < lat + hold);
            snoop_inv = (k == snoop_k);
            snoop_addr = saddr;

            req = (kind != K_NOP) && pass && (k <= lat);
            if (kind == K_NOP || !pass) begin
                e_stall = 0; e_mw = hold_in ? PIPE_STALL : PIPE_ENABLE; e_load = 0;
            end else if (k < lat) begin
                e_stall = 1; e_mw = PIPE_STALL; e_load = 0;
            end else begin
                e_stall = (k > lat) && (k < lat + hold);
                e_mw    = (k < lat + hold) ? PIPE_STALL : PIPE_ENABLE;
                e_load  = result;
            end
            #1;
            chk("dmemREN", 32'(dmemREN), 32'(req && rdop));
            chk("dmemWEN", 32'(dmemWEN), 32'(req && wrop));
            if (req) chk("dmemaddr", dmemaddr, addr & 32'hFFFF_FFFC);
            if (req && wrop) chk("dmemstore", dmemstore, sdata);
            chk("mem_stall", 32'(mem_stall), 32'(e_stall));
            chk("mw_state", 32'(mw_state), 32'(e_mw));
            chk("dmemload_mem", dmemload_mem, e_load);

            if (kind != K_NOP && k == lat) begin
                if (kind == K_LL) begin m_valid = 1; m_word = addr[31:2]; end
                if (kind == K_SC) m_valid = 0;
                if (kind == K_SW && m_word == addr[31:2]) m_valid = 0;
            end
            if (k == snoop_k && m_word == saddr[31:2]) m_valid = 0;
        end
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] base [3];
        base[0] = 32'h100; base[1] = 32'h104; base[2] = 32'h300;
        return base[$urandom_range(2, 0)] | 32'($urandom_range(3, 0));
    endfunction

    initial begin
        drive_idle();
        nRST = 0;
        #12;
        chk("rst_ren", 32'(dmemREN), 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_mw", 32'(mw_state), 32'(PIPE_ENABLE));
        @(negedge CLK);
        nRST = 1;
        #1;
        chk("idle_mw", 32'(mw_state), 32'(PIPE_ENABLE));
        chk("idle_load", dmemload_mem, 0);

        run_op(K_LW, 32'h104, 0, 32'hDEADBEEF, 0, 0, -1, 0);
        run_op(K_SW, 32'h200, 32'h55, $urandom, 3, 0, -1, 0);
        run_op(K_LW, 32'h108, 0, 32'hCAFE0001, 0, 2, -1, 0);
        run_op(K_LL, 32'h300, 0, 32'h11, 1, 0, -1, 0);
        run_op(K_SC, 32'h300, 32'd7, $urandom, 1, 0, -1, 0);
        run_op(K_SC, 32'h300, 32'd7, $urandom, 1, 0, -1, 0);
        run_op(K_LL, 32'h300, 0, 32'h22, 0, 0, -1, 0);
        run_op(K_NOP, 0, 0, 0, 0, 0, 0, 32'h302);
        run_op(K_SC, 32'h300, 32'd9, $urandom, 0, 0, -1, 0);
        run_op(K_LL, 32'h300, 0, 32'h33, 0, 0, -1, 0);
        run_op(K_NOP, 0, 0, 0, 0, 0, 0, 32'h304);
        run_op(K_SC, 32'h300, 32'd9, $urandom, 2, 1, -1, 0);
        run_op(K_LL, 32'h300, 0, 32'h44, 0, 0, 0, 32'h300);
        run_op(K_SC, 32'h300, 32'd9, $urandom, 0, 0, -1, 0);

        // Reset in the middle of a long miss abandons the access and the link.
        run_op(K_LL, 32'h300, 0, 32'h55, 0, 0, -1, 0);
        @(negedge CLK);
        valid_mem = 1; dREN_mem = 1; dWEN_mem = 0; ll_mem = 0; sc_mem = 0;
        addr_mem = 32'h100; dhit = 0; hold_in = 0;
        #1;
        chk("miss_ren", 32'(dmemREN), 1);
        chk("miss_stall", 32'(mem_stall), 1);
        @(negedge CLK);
        #1;
        chk("wait_ren", 32'(dmemREN), 1);
        #2;
        nRST = 0;
        #1;
        chk("arst_ren", 32'(dmemREN), 0);
        chk("arst_stall", 32'(mem_stall), 0);
        m_valid = 0;
        @(negedge CLK);
        drive_idle();
        nRST = 1;
        run_op(K_LW, 32'h100, 0, 32'h1234_5678, 1, 0, -1, 0);
        run_op(K_SC, 32'h300, 32'd1, $urandom, 0, 0, -1, 0);

        for (int i = 0; i < 400; i++) begin
            int          kind, lat, hold, sk;
            logic [31:0] a;
            kind = $urandom_range(4, 0);
            a    = pick_addr();
            lat  = $urandom_range(3, 0);
            hold = $urandom_range(2, 0);
            sk   = -1;
            if ($urandom_range(2, 0) == 0) sk = (kind == K_SC) ? 0 : $urandom_range(lat + hold, 0);
            run_op(kind, a, $urandom, $urandom, lat, hold, sk, pick_addr());
        end

        @(negedge CLK);
        drive_idle();
        #1;
        chk("final_idle_stall", 32'(mem_stall), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_memory_stage.md
Name: pipeline_memory_stage

Overview:
- MEM-stage controller between the EX/MEM latch and the MEM/WB latch.
- Drives the data-cache request and handshake, and holds the stage while the cache misses.
- Captures load data and generates mw_state for the MEM/WB latch.
- Keeps the LL/SC link register: sets it on LL, clears it on local stores and on snoop invalidations.

Parameters:
WORD_W, 32, data/address width
LINK_W, 30, stored link-address width (word address, addr[31:2])

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
valid_mem  in  1  EX/MEM holds a real instruction
dREN_mem  in  1  load (LW or LL)
dWEN_mem  in  1  store (SW or SC)
ll_mem  in  1  instruction is LL (with dREN_mem)
sc_mem  in  1  instruction is SC (with dWEN_mem)
addr_mem  in  32  ALU result, byte address
store_data_mem  in  32  rt value to store
hold_in  in  1  pipeline-wide freeze from fetch/hazard logic
dhit  in  1  cache completes current request this cycle
dmemload  in  32  cache read data, valid with dhit
snoop_inv  in  1  coherence invalidation this cycle
snoop_addr  in  32  invalidated address
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  32  {addr_mem[31:2],2'b00}
dmemstore  out  32  store_data_mem
dmemload_mem  out  32  value forwarded to MEM/WB: load data, or SC result {31'b0,success}
mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
mw_state  out  pipe_state_t  PIPE_ENABLE or PIPE_STALL to the MEM/WB latch

Behaviour:
- Clock and reset: one clock, CLK; nRST is asynchronous, active-low.
- Reset values:
  - FSM = IDLE; link_valid = 0; link_addr = 0; data_q = 0.
  - Outputs follow from IDLE with valid_mem = 0: no request, mem_stall = 0, mw_state = PIPE_ENABLE.
- Memory op (memop): valid_mem & (dREN_mem | dWEN_mem), excluding a failing SC.
  - SC passes iff link_valid & (link_addr == addr_mem[31:2]).
  - A failing SC issues no cache request. It completes in its first cycle with dmemload_mem = 0, without entering WAIT.
- Requests: dmemREN/dmemWEN are combinational from dREN_mem/dWEN_mem.
  - Asserted only in IDLE (when memop) and in WAIT.
  - Never asserted in DONE.
- Word accesses only; addr[1:0] is ignored.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, no memop: mw_state = hold_in ? PIPE_STALL : PIPE_ENABLE; mem_stall = 0.
  - IDLE, memop with dhit (zero extra latency): capture dmemload into data_q.
    - If hold_in: go to DONE, mw_state = PIPE_STALL.
    - Else: stay in IDLE, mw_state = PIPE_ENABLE.
  - IDLE, memop without dhit: go to WAIT; mem_stall = 1; mw_state = PIPE_STALL.
  - WAIT: keep the request asserted and the address stable; mem_stall = 1 until dhit.
    - On dhit, act as in the IDLE-hit case: go to DONE if hold_in, else return to IDLE with mw_state = PIPE_ENABLE and mem_stall = 0 in that same cycle.
  - DONE: no request; mem_stall = 1; mw_state = PIPE_STALL.
    - When hold_in drops: mw_state = PIPE_ENABLE, mem_stall = 0, next state IDLE.
    - This guarantees a completed store is never re-issued.
- dmemload_mem:
  - In the dhit cycle: passes dmemload through combinationally.
  - In DONE: data_q.
  - For SC: {31'b0, success}.
  - Otherwise: don't-care, driven as 0.
- Link register, updated on the completing cycle:
  - LL completion: link_valid = 1, link_addr = addr[31:2].
  - SC completion (pass or fail): link_valid = 0.
  - SW completion to link_addr: link_valid = 0.
  - snoop_inv with snoop_addr[31:2] == link_addr: link_valid = 0.
  - Snoop in the same cycle as an LL completion to the same word: the clear wins, link_valid = 0.
- Async reset mid-WAIT: requests drop immediately and the FSM returns to IDLE; the in-flight access is abandoned.
- This block never emits PIPE_NOP; flushes belong to the hazard unit.

Decomposition:
- cpu_types_pkg holds:
  - pipe_state_t {PIPE_ENABLE, PIPE_STALL, PIPE_NOP}
  - memstate_t {MEM_IDLE, MEM_WAIT, MEM_DONE}
  - word_t
- One natural sub-module, link_register: holds link_valid/link_addr and the match/clear logic, with set/clear/snoop inputs and valid/match outputs.

Test Plan:
- LW, addr 0x104, dhit in the first cycle, dmemload 0xDEADBEEF, hold_in = 0 -> dmemREN = 1 one cycle, dmemaddr = 0x104, dmemload_mem = 0xDEADBEEF, mw_state = PIPE_ENABLE, mem_stall never 1.
- SW, addr 0x200, data 0x55, dhit after 3 cycles -> dmemWEN high 4 cycles, mem_stall = 1 for 3 cycles, PIPE_ENABLE on cycle 4, then IDLE.
- LW hit with hold_in = 1 for 2 more cycles -> FSM in DONE for 2 cycles with no request, dmemload_mem = data_q, PIPE_ENABLE when hold_in falls.
- LL 0x300 then SC 0x300 data 7 -> SC writes 7 and dmemload_mem = 1; a second SC 0x300 -> no dmemWEN, dmemload_mem = 0.
- LL 0x300, then snoop_inv with 0x302 before the SC -> SC fails with no request and result 0. A snoop to 0x304 instead leaves the link intact.
- nRST low during WAIT of a 5-cycle miss -> dmemREN = 0 immediately, mem_stall = 0, link_valid = 0; after release, a new LW proceeds normally.
